int_reg_write_port_arbiter: RTL and testbench



---
 rtl/int_reg_write_port_arbiter_pkg.sv | 25 ++
 rtl/int_write_port_buffer.sv | 60 ++++++
 rtl/int_reg_write_port_arbiter.sv | 101 ++++++++++
 tb/tb_int_reg_write_port_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/int_reg_write_port_arbiter_pkg.sv
// Shared types and helpers for the integer register-file write-port arbiter.
// The request struct fixes the payload widths used by the arbiter and its buffers.
package int_reg_write_port_arbiter_pkg;
  localparam int REQ_NUM_DEF   = 4;
  localparam int PORT_NUM_DEF  = 2;
  localparam int BUF_DEPTH_DEF = 2;
  localparam int PREG_W        = 7;
  localparam int DATA_W        = 32;
  localparam int AL_PTR_W      = 6;

  typedef struct packed {
    logic [PREG_W-1:0]   regNum;
    logic [DATA_W-1:0]   data;
    logic [AL_PTR_W-1:0] alPtr;
  } IntWritePortReq;

  // Active-list range [head, tail) with wrap; head == tail is an empty range.
  function automatic logic in_flush_range(input logic [AL_PTR_W-1:0] p,
                                          input logic [AL_PTR_W-1:0] head,
                                          input logic [AL_PTR_W-1:0] tail);
    if (head < tail)      return (p >= head) && (p < tail);
    else if (head > tail) return (p >= head) || (p < tail);
    else                  return 1'b0;
  endfunction
endpackage

// File: rtl/int_write_port_buffer.sv
// Per-requester in-order skid queue; flushed entries are dropped and survivors compacted.
module int_write_port_buffer
  import int_reg_write_port_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  IntWritePortReq      in_entry,
  input  logic                pop,
  input  logic                flush_valid,
  input  logic [AL_PTR_W-1:0] flush_head,
  input  logic [AL_PTR_W-1:0] flush_tail,
  output logic                head_valid,
  output IntWritePortReq      head_entry
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  IntWritePortReq mem [BUF_DEPTH];
  IntWritePortReq mem_nxt [BUF_DEPTH];
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           push;

  assign in_ready   = cnt < CW'(BUF_DEPTH);
  // A request landing inside the flush range still handshakes, but is not stored.
  assign push       = in_valid && in_ready &&
                      !(flush_valid && in_flush_range(in_entry.alPtr, flush_head, flush_tail));
  assign head_entry = mem[0];
  assign head_valid = (cnt != '0) &&
                      !(flush_valid && in_flush_range(mem[0].alPtr, flush_head, flush_tail));

  always_comb begin
    mem_nxt = mem;
    cnt_nxt = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if ((CW'(i) < cnt) && !(pop && (i == 0)) &&
          !(flush_valid && in_flush_range(mem[i].alPtr, flush_head, flush_tail))) begin
        mem_nxt[IW'(cnt_nxt)] = mem[i];
        cnt_nxt = cnt_nxt + CW'(1);
      end
    end
    if (push) begin
      mem_nxt[IW'(cnt_nxt)] = in_entry;
      cnt_nxt = cnt_nxt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      cnt <= cnt_nxt;
      mem <= mem_nxt;
    end
  end
endmodule

// File: rtl/int_reg_write_port_arbiter.sv
// Round-robin arbiter mapping buffered integer writebacks onto PORT_NUM
// register-file write ports, with selective flush and an oversubscription counter.
module int_reg_write_port_arbiter
  import int_reg_write_port_arbiter_pkg::*;
#(
  parameter int REQ_NUM      = REQ_NUM_DEF,
  parameter int PORT_NUM     = PORT_NUM_DEF,
  parameter int BUF_DEPTH    = BUF_DEPTH_DEF,
  parameter int PREG_WIDTH   = PREG_W,
  parameter int DATA_WIDTH   = DATA_W,
  parameter int AL_PTR_WIDTH = AL_PTR_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [REQ_NUM-1:0]                  reqValid,
  output logic [REQ_NUM-1:0]                  reqReady,
  input  logic [REQ_NUM-1:0][PREG_WIDTH-1:0]  reqRegNum,
  input  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]  reqData,
  input  logic [REQ_NUM-1:0][AL_PTR_WIDTH-1:0] reqAlPtr,
  input  logic                                stall,
  input  logic                                flushValid,
  input  logic [AL_PTR_WIDTH-1:0]             flushHeadPtr,
  input  logic [AL_PTR_WIDTH-1:0]             flushTailPtr,
  output logic [PORT_NUM-1:0]                 portWE,
  output logic [PORT_NUM-1:0][PREG_WIDTH-1:0] portRegNum,
  output logic [PORT_NUM-1:0][DATA_WIDTH-1:0] portData,
  output logic [15:0]                         conflictCount
);
  localparam int RW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int GW = $clog2(PORT_NUM + 1);
  localparam int EW = $clog2(REQ_NUM + 1);

  IntWritePortReq [REQ_NUM-1:0] head;
  logic [REQ_NUM-1:0] elig, grant;
  logic [RW-1:0]      rr_ptr, rr_nxt, idx;
  logic [RW:0]        scan;
  logic [GW-1:0]      n_gnt;
  logic [EW-1:0]      n_elig;

  for (genvar g = 0; g < REQ_NUM; g++) begin : g_buf
    IntWritePortReq entry;
    assign entry.regNum = reqRegNum[g];
    assign entry.data   = reqData[g];
    assign entry.alPtr  = reqAlPtr[g];

    int_write_port_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (reqValid[g]),
      .in_ready   (reqReady[g]),
      .in_entry   (entry),
      .pop        (grant[g]),
      .flush_valid(flushValid),
      .flush_head (flushHeadPtr),
      .flush_tail (flushTailPtr),
      .head_valid (elig[g]),
      .head_entry (head[g])
    );
  end

  // Scan from rr_ptr; the k-th grant in scan order drives port k.
  always_comb begin
    grant      = '0;
    portWE     = '0;
    portRegNum = '0;
    portData   = '0;
    rr_nxt     = rr_ptr;
    n_gnt      = '0;
    n_elig     = '0;
    scan       = '0;
    idx        = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      scan = {1'b0, rr_ptr} + (RW+1)'(k);
      if (scan >= (RW+1)'(REQ_NUM)) scan = scan - (RW+1)'(REQ_NUM);
      idx = scan[RW-1:0];
      if (elig[idx]) begin
        n_elig = n_elig + EW'(1);
        if (!stall && (n_gnt < GW'(PORT_NUM))) begin
          grant[idx]                = 1'b1;
          portWE[n_gnt[PW-1:0]]     = 1'b1;
          portRegNum[n_gnt[PW-1:0]] = head[idx].regNum;
          portData[n_gnt[PW-1:0]]   = head[idx].data;
          n_gnt  = n_gnt + GW'(1);
          rr_nxt = (idx == RW'(REQ_NUM - 1)) ? '0 : idx + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr        <= '0;
      conflictCount <= '0;
    end else begin
      rr_ptr <= rr_nxt;
      if (!stall && (n_elig > EW'(PORT_NUM)) && (conflictCount != 16'hFFFF))
        conflictCount <= conflictCount + 16'd1;
    end
  end
endmodule

// File: tb/tb_int_reg_write_port_arbiter.sv
// Directed bench for the write-port arbiter: grant order, stall, flush, fairness, reset.
module tb_int_reg_write_port_arbiter;
  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       reqValid;
  logic [3:0]       reqReady;
  logic [3:0][6:0]  reqRegNum;
  logic [3:0][31:0] reqData;
  logic [3:0][5:0]  reqAlPtr;
  logic             stall;
  logic             flushValid;
  logic [5:0]       flushHeadPtr, flushTailPtr;
  logic [1:0]       portWE;
  logic [1:0][6:0]  portRegNum;
  logic [1:0][31:0] portData;
  logic [15:0]      conflictCount;

  int n_chk = 0;
  int n_fail = 0;
  int gcnt [4];
  int last [4];
  int maxgap;
  int r;

  int_reg_write_port_arbiter dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady),
    .reqRegNum(reqRegNum), .reqData(reqData), .reqAlPtr(reqAlPtr),
    .stall(stall), .flushValid(flushValid), .flushHeadPtr(flushHeadPtr),
    .flushTailPtr(flushTailPtr), .portWE(portWE), .portRegNum(portRegNum),
    .portData(portData), .conflictCount(conflictCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int q, input logic [6:0] rn, input logic [31:0] d, input logic [5:0] al);
    reqValid[q]  = 1'b1;
    reqRegNum[q] = rn;
    reqData[q]   = d;
    reqAlPtr[q]  = al;
  endtask

  initial begin
    rst = 1'b0; reqValid = '0; reqRegNum = '0; reqData = '0; reqAlPtr = '0;
    stall = 1'b0; flushValid = 1'b0; flushHeadPtr = '0; flushTailPtr = '0;
    #12;
    chk("rst_we", 32'(portWE), 32'h0);
    chk("rst_ready", 32'(reqReady), 32'hF);
    chk("rst_conflict", 32'(conflictCount), 32'h0);
    rst = 1'b1;
    tick;

    // Four single entries, two ports: two cycles of writes, one conflict.
    for (int i = 0; i < 4; i++) load(i, 7'(8'h10 + i), 32'hA000_0000 + 32'(i), 6'(i));
    tick;
    reqValid = '0;
    #1;
    chk("rr1_we", 32'(portWE), 32'h3);
    chk("rr1_p0", 32'(portRegNum[0]), 32'h10);
    chk("rr1_p1", 32'(portRegNum[1]), 32'h11);
    chk("rr1_d1", portData[1], 32'hA000_0001);
    tick;
    chk("rr2_we", 32'(portWE), 32'h3);
    chk("rr2_p0", 32'(portRegNum[0]), 32'h12);
    chk("rr2_p1", 32'(portRegNum[1]), 32'h13);
    chk("rr2_conflict", 32'(conflictCount), 32'h1);
    tick;
    chk("rr3_idle", 32'(portWE), 32'h0);

    // Stall fills requester 2; the third entry waits for a pop.
    stall = 1'b1;
    load(2, 7'h20, 32'hB0, 6'd20);
    #1 chk("st_ready0", 32'(reqReady[2]), 32'h1);
    tick;
    load(2, 7'h21, 32'hB1, 6'd21);
    #1 chk("st_ready1", 32'(reqReady[2]), 32'h1);
    chk("st_we0", 32'(portWE), 32'h0);
    tick;
    load(2, 7'h22, 32'hB2, 6'd22);
    #1 chk("st_full", 32'(reqReady[2]), 32'h0);
    tick;
    chk("st_we_held", 32'(portWE), 32'h0);
    stall = 1'b0;
    #1;
    chk("st_rel_we", 32'(portWE), 32'h1);
    chk("st_rel_p0", 32'(portRegNum[0]), 32'h20);
    chk("st_rel_ready", 32'(reqReady[2]), 32'h0);
    tick;
    chk("st_e1", 32'(portRegNum[0]), 32'h21);
    chk("st_ready_back", 32'(reqReady[2]), 32'h1);
    tick;
    reqValid = '0;
    #1;
    chk("st_e2", 32'(portRegNum[0]), 32'h22);
    tick;
    chk("st_drain", 32'(portWE), 32'h0);

    // Wrapping flush range 61..1: alPtr 62 and 1 drop, 60 and 5 write.
    stall = 1'b1;
    load(0, 7'h30, 32'hC0, 6'd60);
    load(1, 7'h31, 32'hC1, 6'd62);
    load(2, 7'h32, 32'hC2, 6'd1);
    load(3, 7'h33, 32'hC3, 6'd5);
    tick;
    reqValid = '0; stall = 1'b0;
    flushValid = 1'b1; flushHeadPtr = 6'd61; flushTailPtr = 6'd2;
    load(1, 7'h34, 32'hC4, 6'd63);
    load(2, 7'h35, 32'hC5, 6'd30);
    #1;
    chk("fl_we", 32'(portWE), 32'h3);
    chk("fl_p0", 32'(portRegNum[0]), 32'h33);
    chk("fl_p1", 32'(portRegNum[1]), 32'h30);
    chk("fl_ready", 32'(reqReady), 32'hF);
    tick;
    reqValid = '0; flushValid = 1'b0;
    #1;
    chk("fl_surv_we", 32'(portWE), 32'h1);
    chk("fl_surv_p0", 32'(portRegNum[0]), 32'h35);
    tick;
    chk("fl_empty", 32'(portWE), 32'h0);
    chk("fl_conflict", 32'(conflictCount), 32'h1);

    // Empty flush range (head == tail) removes nothing.
    stall = 1'b1;
    load(0, 7'h40, 32'hD0, 6'd10);
    tick;
    reqValid = '0; stall = 1'b0;
    flushValid = 1'b1; flushHeadPtr = 6'd10; flushTailPtr = 6'd10;
    #1;
    chk("fe_we", 32'(portWE), 32'h1);
    chk("fe_p0", 32'(portRegNum[0]), 32'h40);
    tick;
    flushValid = 1'b0;
    #1 chk("fe_done", 32'(portWE), 32'h0);

    // Sustained load from all four requesters over eight grant cycles.
    for (int i = 0; i < 4; i++) begin
      load(i, 7'(8'h50 + i), 32'hE000_0000 + 32'(i), 6'(i));
      gcnt[i] = 0;
      last[i] = 0;
    end
    maxgap = 0;
    for (int c = 0; c <= 8; c++) begin
      #1;
      if (c > 0) begin
        for (int p = 0; p < 2; p++) begin
          if (portWE[p] && portRegNum[p] >= 7'h50 && portRegNum[p] < 7'h54) begin
            r = int'(portRegNum[p]) - 'h50;
            gcnt[r]++;
            if (c - last[r] > maxgap) maxgap = c - last[r];
            last[r] = c;
          end
        end
      end
      tick;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("fair_cnt%0d", i), 32'(gcnt[i]), 32'd4);
    chk("fair_gap", 32'(maxgap <= 2), 32'h1);
    chk("fair_conflict", 32'(conflictCount), 32'd9);

    // Fill every buffer, then reset between edges.
    stall = 1'b1;
    tick;
    tick;
    stall = 1'b0;
    #1;
    chk("pre_rst_we", 32'(portWE), 32'h3);
    chk("pre_rst_ready", 32'(reqReady), 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_we", 32'(portWE), 32'h0);
    chk("mid_rst_ready", 32'(reqReady), 32'hF);
    chk("mid_rst_conflict", 32'(conflictCount), 32'h0);
    reqValid = '0;
    tick;
    rst = 1'b1;
    tick;
    chk("post_rst_we", 32'(portWE), 32'h0);
    tick;
    chk("post_rst_idle", 32'(portWE), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
